// File: rtl/minicpu_pkg.sv
// Shared types and constants for the MiniCPU program sequencer: instruction layout, opcodes, FSM states.
package minicpu_pkg;

  localparam int INSTR_W = 13;

  // Instruction word: {opcode, wr_addr, rd_addr1, rd_addr2, imm}
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 10;
  localparam int WR_MSB  = 9;
  localparam int WR_LSB  = 8;
  localparam int RD1_MSB = 7;
  localparam int RD1_LSB = 6;
  localparam int RD2_MSB = 5;
  localparam int RD2_LSB = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] NOP_OP  = 3'b000;
  localparam logic [2:0] HALT_OP = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/minicpu_sequencer_if.sv
// Host/CPU-facing bundle of the program sequencer; trace signals exist only with MINICPU_SEQ_TRACE_EN.
interface minicpu_sequencer_if
  import minicpu_pkg::*;
#(
  parameter int PC_W = 4
);
  logic               load_en;
  logic [PC_W-1:0]    load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic [PC_W-1:0]    pc;
  logic [3:0]         last_result;
  logic [2:0]         cpu_opcode;
  logic [1:0]         cpu_wr_addr;
  logic [1:0]         cpu_rd_addr1;
  logic [1:0]         cpu_rd_addr2;
  logic [3:0]         cpu_wr_data;
  logic [3:0]         cpu_alu_result;
  logic               cpu_reg_write;
`ifdef MINICPU_SEQ_TRACE_EN
  logic               trace_valid;
  logic [PC_W-1:0]    trace_pc;
  logic [3:0]         trace_result;
  logic               trace_wrote;
  logic [7:0]         instr_count;
`endif

  modport master (
    output load_en, load_addr, load_data, start, abort, cpu_alu_result, cpu_reg_write,
`ifdef MINICPU_SEQ_TRACE_EN
    input  trace_valid, trace_pc, trace_result, trace_wrote, instr_count,
`endif
    input  busy, done, pc, last_result,
           cpu_opcode, cpu_wr_addr, cpu_rd_addr1, cpu_rd_addr2, cpu_wr_data
  );

  modport slave (
    input  load_en, load_addr, load_data, start, abort, cpu_alu_result, cpu_reg_write,
`ifdef MINICPU_SEQ_TRACE_EN
    output trace_valid, trace_pc, trace_result, trace_wrote, instr_count,
`endif
    output busy, done, pc, last_result,
           cpu_opcode, cpu_wr_addr, cpu_rd_addr1, cpu_rd_addr2, cpu_wr_data
  );

endinterface

// File: rtl/minicpu_prog_mem.sv
// Program memory: synchronous write, registered read with write-through on a same-address collision.
module minicpu_prog_mem
  import minicpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Forwarding lets a load to mem[0] in the start cycle reach the first fetch.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (we_i && (waddr_i == raddr_i)) rdata_o <= wdata_i;
    else                              rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/minicpu_sequencer.sv
// MiniCPU program sequencer: IDLE (load/await start) | FETCH (instr reg holds mem[pc]) | EXEC (drive CPU,
// capture result) | DONE (done pulse). Optional trace outputs enabled by MINICPU_SEQ_TRACE_EN.
module minicpu_sequencer
  import minicpu_pkg::*;
#(
  parameter int         PROG_DEPTH  = 16,
  parameter int         PC_W        = $clog2(PROG_DEPTH),
  parameter logic [2:0] NOP_OPCODE  = NOP_OP,
  parameter logic [2:0] HALT_OPCODE = HALT_OP
) (
  input logic                 clk,
  input logic                 rst,
  minicpu_sequencer_if.slave  bus
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);

  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [3:0]         last_result_q, last_result_d;
  logic [2:0]         op_q, op_d;
  logic [1:0]         wr_q, wr_d, rd1_q, rd1_d, rd2_q, rd2_d;
  logic [3:0]         imm_q, imm_d;
  logic [INSTR_W-1:0] instr;

  // Read address follows pc_d so the word for the next FETCH is already registered when FETCH begins.
  minicpu_prog_mem #(.DEPTH(PROG_DEPTH), .AW(PC_W)) u_prog_mem (
    .clk     (clk),
    .we_i    ((state_q == IDLE) && bus.load_en),
    .waddr_i (bus.load_addr),
    .wdata_i (bus.load_data),
    .raddr_i (pc_d),
    .rdata_o (instr)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    last_result_d = last_result_q;
    op_d          = NOP_OPCODE;
    wr_d          = '0;
    rd1_d         = '0;
    rd2_d         = '0;
    imm_d         = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: begin
        if (bus.abort) state_d = IDLE;
        else if (instr[OP_MSB:OP_LSB] == HALT_OPCODE) state_d = DONE;
        else begin
          state_d = EXEC;
          op_d    = instr[OP_MSB:OP_LSB];
          wr_d    = instr[WR_MSB:WR_LSB];
          rd1_d   = instr[RD1_MSB:RD1_LSB];
          rd2_d   = instr[RD2_MSB:RD2_LSB];
          imm_d   = instr[IMM_MSB:IMM_LSB];
        end
      end
      EXEC: begin
        last_result_d = bus.cpu_alu_result;
        if (bus.abort) state_d = IDLE;
        else if (pc_q == PC_LAST) state_d = DONE;
        else begin
          pc_d    = pc_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      last_result_q <= '0;
      op_q          <= NOP_OPCODE;
      wr_q          <= '0;
      rd1_q         <= '0;
      rd2_q         <= '0;
      imm_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      last_result_q <= last_result_d;
      op_q          <= op_d;
      wr_q          <= wr_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      imm_q         <= imm_d;
    end
  end

  assign bus.busy         = (state_q == FETCH) || (state_q == EXEC);
  assign bus.done         = (state_q == DONE);
  assign bus.pc           = pc_q;
  assign bus.last_result  = last_result_q;
  assign bus.cpu_opcode   = op_q;
  assign bus.cpu_wr_addr  = wr_q;
  assign bus.cpu_rd_addr1 = rd1_q;
  assign bus.cpu_rd_addr2 = rd2_q;
  assign bus.cpu_wr_data  = imm_q;

`ifdef MINICPU_SEQ_TRACE_EN
  logic [7:0] instr_count_q, instr_count_d;
  logic       exec_now;

  assign exec_now = (state_q == EXEC);

  always_comb begin
    instr_count_d = instr_count_q;
    if ((state_q == IDLE) && bus.start) instr_count_d = '0;
    else if (exec_now && (instr_count_q != 8'hFF)) instr_count_d = instr_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) instr_count_q <= '0;
    else     instr_count_q <= instr_count_d;
  end

  assign bus.trace_valid  = exec_now;
  assign bus.trace_pc     = exec_now ? pc_q : '0;
  assign bus.trace_result = exec_now ? bus.cpu_alu_result : '0;
  assign bus.trace_wrote  = exec_now & bus.cpu_reg_write;
  assign bus.instr_count  = instr_count_q;
`else
  logic unused_reg_write;
  assign unused_reg_write = bus.cpu_reg_write;
`endif

endmodule

// File: tb/tb_minicpu_sequencer.sv
// Randomized self-checking bench for minicpu_sequencer; trace checks active with MINICPU_SEQ_TRACE_EN.
module tb_minicpu_sequencer;
  import minicpu_pkg::*;

  localparam int PD = 16;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst;

  minicpu_sequencer_if #(.PC_W(PW)) sif ();

  minicpu_sequencer #(.PROG_DEPTH(PD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [12:0] mdl_mem [PD];
  logic [3:0]  exp_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    sif.load_en        = 1'b0;
    sif.load_addr      = '0;
    sif.load_data      = '0;
    sif.start          = 1'b0;
    sif.abort          = 1'b0;
    sif.cpu_alu_result = '0;
    sif.cpu_reg_write  = 1'b0;
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, ".op"},  32'(sif.cpu_opcode),   32'(NOP_OP));
    chk({tag, ".wr"},  32'(sif.cpu_wr_addr),  0);
    chk({tag, ".rd1"}, 32'(sif.cpu_rd_addr1), 0);
    chk({tag, ".rd2"}, 32'(sif.cpu_rd_addr2), 0);
    chk({tag, ".imm"}, 32'(sif.cpu_wr_data),  0);
  endtask

  task automatic load_word(input int addr, input logic [12:0] data);
    sif.load_en   = 1'b1;
    sif.load_addr = PW'(addr);
    sif.load_data = data;
    tick();
    sif.load_en   = 1'b0;
    mdl_mem[addr] = data;
  endtask

  function automatic logic [12:0] rand_word(input bit allow_halt);
    logic [12:0] w;
    w = 13'($urandom);
    if (allow_halt && ($urandom_range(0, 5) == 0)) w[12:10] = HALT_OP;
    else w[12:10] = 3'($urandom_range(0, 6));
    return w;
  endfunction

  // mode 0: run to completion, 1: abort in EXEC of instruction arg, 2: reset in EXEC of instruction arg
  task automatic run(input int mode_in, input int arg_in, input bit co_load, input logic [12:0] co_data);
    int          h, n_exec, end_cyc, stop_cyc, mode, arg, fin_pc;
    logic [12:0] w;
    mode = mode_in;
    arg  = arg_in;
    if (co_load) mdl_mem[0] = co_data;
    h = -1;
    for (int i = 0; i < PD; i++)
      if (h < 0 && mdl_mem[i][12:10] == HALT_OP) h = i;
    n_exec  = (h < 0) ? PD : h;
    end_cyc = (h < 0) ? 2 * PD + 1 : 2 * h + 2;
    fin_pc  = (h < 0) ? PD - 1 : h;
    if (n_exec == 0) mode = 0;
    if (mode != 0 && arg >= n_exec) arg = n_exec - 1;
    stop_cyc = (mode == 0) ? end_cyc : 2 + 2 * arg;

    sif.start = 1'b1;
    if (co_load) begin
      sif.load_en   = 1'b1;
      sif.load_addr = '0;
      sif.load_data = co_data;
    end
    tick();
    quiet_inputs();

    for (int k = 1; k <= stop_cyc; k++) begin
      chk("last_result", 32'(sif.last_result), 32'(exp_last));
      if (mode == 0 && k == end_cyc) begin
        chk("done", 32'(sif.done), 1);
        chk("busy_done", 32'(sif.busy), 0);
        chk("pc_done", 32'(sif.pc), 32'(fin_pc));
        chk_nop("done_nop");
`ifdef MINICPU_SEQ_TRACE_EN
        chk("instr_count_done", 32'(sif.instr_count), 32'(n_exec));
        chk("trace_valid_done", 32'(sif.trace_valid), 0);
`endif
        sif.abort = 1'($urandom);
      end else begin
        chk("busy", 32'(sif.busy), 1);
        chk("done_low", 32'(sif.done), 0);
        if (k % 2 == 0) begin
          w = mdl_mem[(k - 2) / 2];
          chk("pc_exec", 32'(sif.pc), 32'((k - 2) / 2));
          chk("exec_op",  32'(sif.cpu_opcode),   32'(w[12:10]));
          chk("exec_wr",  32'(sif.cpu_wr_addr),  32'(w[9:8]));
          chk("exec_rd1", 32'(sif.cpu_rd_addr1), 32'(w[7:6]));
          chk("exec_rd2", 32'(sif.cpu_rd_addr2), 32'(w[5:4]));
          chk("exec_imm", 32'(sif.cpu_wr_data),  32'(w[3:0]));
        end else begin
          chk("pc_fetch", 32'(sif.pc), 32'((k - 1) / 2));
          chk_nop("fetch_nop");
        end
      end
      sif.cpu_alu_result = 4'($urandom);
      sif.cpu_reg_write  = 1'($urandom);
      sif.load_en        = 1'($urandom);
      sif.load_addr      = ($urandom_range(0, 1) == 0) ? PW'(3) : PW'($urandom);
      sif.load_data      = 13'($urandom);
      sif.start          = ($urandom_range(0, 2) == 0);
      #1;
`ifdef MINICPU_SEQ_TRACE_EN
      chk("trace_valid", 32'(sif.trace_valid), 32'((k % 2 == 0) && !(mode == 0 && k == end_cyc)));
      if (k % 2 == 0 && !(mode == 0 && k == end_cyc)) begin
        chk("trace_pc", 32'(sif.trace_pc), 32'((k - 2) / 2));
        chk("trace_result", 32'(sif.trace_result), 32'(sif.cpu_alu_result));
        chk("trace_wrote", 32'(sif.trace_wrote), 32'(sif.cpu_reg_write));
        chk("instr_count_exec", 32'(sif.instr_count), 32'((k - 2) / 2));
      end
`endif
      if (k % 2 == 0 && !(mode == 0 && k == end_cyc)) exp_last = sif.cpu_alu_result;
      if (k == stop_cyc && mode == 1) sif.abort = 1'b1;
      if (k == stop_cyc && mode == 2) rst = 1'b1;
      tick();
      quiet_inputs();
      rst = 1'b0;
    end

    if (mode == 2) exp_last = '0;
    chk("busy_after", 32'(sif.busy), 0);
    chk("done_after", 32'(sif.done), 0);
    chk("last_after", 32'(sif.last_result), 32'(exp_last));
    chk_nop("after_nop");
    if (mode == 0) chk("pc_hold", 32'(sif.pc), 32'(fin_pc));
    if (mode == 2) begin
      chk("pc_rst", 32'(sif.pc), 0);
`ifdef MINICPU_SEQ_TRACE_EN
      chk("instr_count_rst", 32'(sif.instr_count), 0);
`endif
    end
    tick();
    chk("done_late", 32'(sif.done), 0);
    chk("busy_late", 32'(sif.busy), 0);
  endtask

  initial begin
    quiet_inputs();
    rst      = 1'b1;
    exp_last = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(sif.busy), 0);
    chk("rst_done", 32'(sif.done), 0);
    chk("rst_pc", 32'(sif.pc), 0);
    chk("rst_last", 32'(sif.last_result), 0);
    chk_nop("rst_nop");
`ifdef MINICPU_SEQ_TRACE_EN
    chk("rst_trace_valid", 32'(sif.trace_valid), 0);
    chk("rst_instr_count", 32'(sif.instr_count), 0);
`endif

    // single instruction then HALT
    load_word(0, {3'b001, 2'd1, 2'd0, 2'd0, 4'd5});
    load_word(1, {HALT_OP, 10'd0});
    run(0, 0, 1'b0, '0);

    // full program, no HALT anywhere
    for (int i = 0; i < PD; i++) load_word(i, rand_word(1'b0));
    run(0, 0, 1'b0, '0);

    // abort in EXEC of pc=2, then restart
    run(1, 2, 1'b0, '0);
    run(0, 0, 1'b0, '0);

    // reset mid-EXEC, memory retained
    run(2, 1, 1'b0, '0);
    run(0, 0, 1'b0, '0);

    // start together with a load to address 0
    run(0, 0, 1'b1, rand_word(1'b0));

    // three-instruction program
    for (int i = 0; i < 3; i++) load_word(i, rand_word(1'b0));
    load_word(3, {HALT_OP, 10'($urandom)});
    run(0, 0, 1'b0, '0);

    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < PD; i++)
        if ($urandom_range(0, 1) == 0) load_word(i, rand_word(1'b1));
      run($urandom_range(0, 2), $urandom_range(0, PD - 1), 1'($urandom), rand_word(1'b1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
